// File: rtl/uart_tx_port.sv
// Byte FIFO feeding an 8N1 serialiser; start bit appears 2 edges after an accepted write, frames are 10*CLK_DIV cycles.
// No backpressure: writes while full are dropped and latch the sticky ovf flag until clr_ovf.
module uart_tx_port #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       full,
    output logic       empty,
    output logic       tx_busy,
    output logic       ovf,
    output logic       tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [DW-1:0]   div;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [7:0]      shreg_nx;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nx;
    logic [7:0]      mem [FIFO_DEPTH];
    logic            bit_end;
    logic            push;
    logic            pop;
    logic            drop;
    logic            tx_nx;

    assign bit_end = (div == DIV_MAX);
    // Full check uses the registered flag, so a same-edge pop never rescues a write.
    assign push    = wr_en & ~full;
    assign drop    = wr_en & full;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (!empty) state_nx = START;
            START: if (bit_end) state_nx = DATA;
            DATA:  if (bit_end && bit_cnt == 3'd7) state_nx = STOP;
            STOP:  if (bit_end) state_nx = empty ? IDLE : START;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        shreg_nx = shreg;
        tx_nx    = 1'b1;
        case (state)
            IDLE: pop = ~empty;
            DATA: if (bit_end) shreg_nx = {1'b0, shreg[7:1]};
            STOP: pop = bit_end & ~empty;
            default: ;
        endcase
        if (pop) shreg_nx = mem[rptr];
        // tx is registered from the post-edge state so it has no input-to-output path.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shreg_nx[0];
            default: tx_nx = 1'b1;
        endcase
        count_nx = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            tx_busy <= 1'b0;
            ovf     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            div <= (state == IDLE || bit_end) ? '0 : div + DW'(1);
            if (state == START && bit_end) begin
                bit_cnt <= '0;
            end else if (state == DATA && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            shreg <= shreg_nx;
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count   <= count_nx;
            full    <= (count_nx == CW'(FIFO_DEPTH));
            empty   <= (count_nx == '0);
            ovf     <= (ovf & ~clr_ovf) | drop;
            tx_busy <= (state_nx != IDLE) | (count_nx != '0);
            tx      <= tx_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset && push) mem[wptr] <= wr_data;
    end

endmodule
